// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ID/EX pipeline definitions: datapath widths and the payload carried from ID into EX.
package id_ex_stage_reg_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CTRL_W     = 16;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  mem_read;
    logic [CTRL_W-1:0]     ctrl;
  } id_ex_payload_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in the downstream stage whose rd feeds a source
// operand of the upstream instruction. x0 never creates a dependence.
module load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  id_valid_i,
  input  logic                  id_uses_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  output logic                  hazard_o
);

  logic ex_is_load_wr;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    ex_is_load_wr = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != '0);
    rs1_hit       = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit       = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i);
    hazard_o      = ex_is_load_wr & id_valid_i & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, valid/ready backpressure and a
// saturating bubble counter. XLEN and CTRL_W must match the package payload definition.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned XLEN   = id_ex_stage_reg_pkg::XLEN,
  parameter int unsigned CTRL_W = id_ex_stage_reg_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  id_mem_read_i,
  input  logic [CTRL_W-1:0]     id_ctrl_i,
  input  logic                  flush_i,
  input  logic                  ex_ready_i,
  output logic                  ex_valid_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [XLEN-1:0]       ex_imm_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  ex_mem_read_o,
  output logic [CTRL_W-1:0]     ex_ctrl_o,
  output logic                  load_use_stall_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  id_ex_payload_t   ex_q, ex_d;
  id_ex_payload_t   id_payload;
  logic             ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             advance;
  logic             load_use_stall;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_q.mem_read),
    .ex_rd_addr_i  (ex_q.rd_addr),
    .id_valid_i    (id_valid_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .hazard_o      (load_use_stall)
  );

  always_comb begin
    id_payload          = '0;
    id_payload.pc       = id_pc_i;
    id_payload.rs1_data = id_rs1_data_i;
    id_payload.rs2_data = id_rs2_data_i;
    id_payload.imm      = id_imm_i;
    id_payload.rs1_addr = id_rs1_addr_i;
    id_payload.rs2_addr = id_rs2_addr_i;
    id_payload.rd_addr  = id_rd_addr_i;
    id_payload.mem_read = id_mem_read_i;
    id_payload.ctrl     = id_ctrl_i;
  end

  assign advance    = ~ex_valid_q | ex_ready_i;
  assign id_ready_o = advance & ~load_use_stall & ~flush_i;

  // Flush beats backpressure and hazards; bubbles keep data fields so only control is scrubbed.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    bubble_d   = bubble_q;
    if (flush_i) begin
      ex_valid_d    = 1'b0;
      ex_d.ctrl     = '0;
      ex_d.mem_read = 1'b0;
    end else if (advance) begin
      if (load_use_stall) begin
        ex_valid_d    = 1'b0;
        ex_d.ctrl     = '0;
        ex_d.mem_read = 1'b0;
        ex_d.rd_addr  = '0;
        if (bubble_q != '1) begin
          bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        ex_valid_d = id_valid_i;
        ex_d       = id_payload;
        if (!id_valid_i) begin
          ex_d.ctrl     = '0;
          ex_d.mem_read = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      bubble_q   <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      bubble_q   <= bubble_d;
    end
  end

  assign ex_valid_o       = ex_valid_q;
  assign ex_pc_o          = ex_q.pc;
  assign ex_rs1_data_o    = ex_q.rs1_data;
  assign ex_rs2_data_o    = ex_q.rs2_data;
  assign ex_imm_o         = ex_q.imm;
  assign ex_rs1_addr_o    = ex_q.rs1_addr;
  assign ex_rs2_addr_o    = ex_q.rs2_addr;
  assign ex_rd_addr_o     = ex_q.rd_addr;
  assign ex_mem_read_o    = ex_q.mem_read;
  assign ex_ctrl_o        = ex_q.ctrl;
  assign load_use_stall_o = load_use_stall;
  assign bubble_cnt_o     = bubble_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus randomized traffic against a
// behavioural model of the stage.
module tb_id_ex_stage_reg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 32;

  logic              clk, rst_n;
  logic              id_valid, id_uses_rs1, id_uses_rs2, id_mem_read, flush, ex_ready;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]        id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_ready, ex_valid, ex_mem_read, load_use_stall;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  int tests = 0;
  int fails = 0;

  // Model of the EX-side view
  logic              mv, mmr;
  logic [XLEN-1:0]   mpc, mrs1d, mrs2d, mimm;
  logic [4:0]        mra1, mra2, mrd;
  logic [CTRL_W-1:0] mctrl;
  logic [CNT_W-1:0]  mcnt;

  id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr), .id_rd_addr_i(id_rd_addr),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2), .id_mem_read_i(id_mem_read),
    .id_ctrl_i(id_ctrl), .flush_i(flush), .ex_ready_i(ex_ready),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1_data),
    .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm), .ex_rs1_addr_o(ex_rs1_addr),
    .ex_rs2_addr_o(ex_rs2_addr), .ex_rd_addr_o(ex_rd_addr), .ex_mem_read_o(ex_mem_read),
    .ex_ctrl_o(ex_ctrl), .load_use_stall_o(load_use_stall), .bubble_cnt_o(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    mv = 0; mmr = 0; mpc = '0; mrs1d = '0; mrs2d = '0; mimm = '0;
    mra1 = '0; mra2 = '0; mrd = '0; mctrl = '0; mcnt = '0;
  endtask

  // A load sitting in EX that writes a register the ID instruction actually reads
  function automatic logic m_hazard();
    if (!mv || !mmr || mrd == 5'd0 || !id_valid) return 1'b0;
    return (id_uses_rs1 && id_rs1_addr == mrd) || (id_uses_rs2 && id_rs2_addr == mrd);
  endfunction

  function automatic logic m_id_ready();
    return (!mv || ex_ready) && !m_hazard() && !flush;
  endfunction

  task automatic step();
    logic adv, hz;
    adv = !mv || ex_ready;
    hz  = m_hazard();
    @(posedge clk);
    if (flush) begin
      mv = 0; mctrl = '0; mmr = 0;
    end else if (adv && hz) begin
      mv = 0; mctrl = '0; mmr = 0; mrd = '0;
      if (mcnt != '1) mcnt = mcnt + 1;
    end else if (adv) begin
      mv = id_valid; mpc = id_pc; mrs1d = id_rs1_data; mrs2d = id_rs2_data; mimm = id_imm;
      mra1 = id_rs1_addr; mra2 = id_rs2_addr; mrd = id_rd_addr;
      mctrl = id_valid ? id_ctrl : '0;
      mmr = id_valid ? id_mem_read : 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_mem_read = 0; flush = 0; ex_ready = 1;
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_ctrl = '0;
  endtask

  task automatic issue(input logic [XLEN-1:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2, input logic mr);
    id_valid = 1; id_pc = pc; id_rd_addr = rd; id_rs1_addr = rs1; id_uses_rs1 = u1;
    id_rs2_addr = rs2; id_uses_rs2 = u2; id_mem_read = mr;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_ctrl = CTRL_W'($urandom_range(1, 16'hFFFF));
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", ex_valid); end
    tests++; if (ex_ctrl !== '0 || ex_pc !== '0) begin fails++; $display("FAIL rst_fields: got ctrl=%h pc=%h want 0", ex_ctrl, ex_pc); end
    tests++; if (bubble_cnt !== '0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", bubble_cnt); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pass_through();
    issue(32'h100, 5'd4, 5'd1, 1, 5'd2, 1, 0);
    id_rs1_data = 32'hDEADBEEF;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL pt_ready_pre: got %0b want 1", id_ready); end
    step();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL pt_valid: got %0b want 1", ex_valid); end
    tests++; if (ex_pc !== 32'h100 || ex_rs1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL pt_data: got pc=%h rs1=%h want 100 deadbeef", ex_pc, ex_rs1_data); end
    tests++; if (ex_ctrl !== mctrl || ex_rd_addr !== 5'd4) begin fails++; $display("FAIL pt_ctrl: got ctrl=%h rd=%0d want %h 4", ex_ctrl, ex_rd_addr, mctrl); end
    // Invalid ID slot: ctrl must be scrubbed even though id_ctrl is nonzero
    id_valid = 0; id_ctrl = 16'hABCD; id_mem_read = 1;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL pt_ready_post: got %0b want 1", id_ready); end
    step();
    tests++; if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_mem_read !== 1'b0) begin fails++; $display("FAIL pt_invalid: got v=%0b ctrl=%h mr=%0b want 0 0 0", ex_valid, ex_ctrl, ex_mem_read); end
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] c0;
    issue(32'h200, 5'd5, 5'd0, 0, 5'd0, 0, 1);
    step();
    c0 = mcnt;
    issue(32'h204, 5'd6, 5'd3, 1, 5'd5, 1, 0);
    #1;
    tests++; if (load_use_stall !== 1'b1 || id_ready !== 1'b0) begin fails++; $display("FAIL lu_stall: got stall=%0b ready=%0b want 1 0", load_use_stall, id_ready); end
    step();
    tests++; if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin fails++; $display("FAIL lu_bubble: got v=%0b ctrl=%h want 0 0", ex_valid, ex_ctrl); end
    tests++; if (bubble_cnt !== c0 + 1) begin fails++; $display("FAIL lu_cnt: got %0d want %0d", bubble_cnt, c0 + 1); end
    tests++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin fails++; $display("FAIL lu_release: got stall=%0b ready=%0b want 0 1", load_use_stall, id_ready); end
    step();
    tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_rd_addr !== 5'd6) begin fails++; $display("FAIL lu_capture: got v=%0b pc=%h rd=%0d want 1 204 6", ex_valid, ex_pc, ex_rd_addr); end
  endtask

  task automatic test_no_hazard();
    issue(32'h300, 5'd0, 5'd0, 0, 5'd0, 0, 1);
    step();
    issue(32'h304, 5'd1, 5'd0, 1, 5'd0, 1, 0);
    #1;
    tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL nh_x0: got stall=%0b want 0", load_use_stall); end
    step();
    issue(32'h308, 5'd7, 5'd0, 0, 5'd0, 0, 1);
    step();
    issue(32'h30C, 5'd2, 5'd7, 0, 5'd8, 1, 0);
    #1;
    tests++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin fails++; $display("FAIL nh_unused: got stall=%0b ready=%0b want 0 1", load_use_stall, id_ready); end
    step();
  endtask

  task automatic test_backpressure_flush();
    logic [CNT_W-1:0] c0;
    issue(32'h400, 5'd9, 5'd0, 0, 5'd0, 0, 1);
    step();
    c0 = mcnt;
    issue(32'h404, 5'd3, 5'd1, 1, 5'd2, 1, 0);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (id_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, id_ready); end
      step();
      tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_rd_addr !== 5'd9) begin fails++; $display("FAIL bp_hold[%0d]: got v=%0b pc=%h rd=%0d want 1 400 9", i, ex_valid, ex_pc, ex_rd_addr); end
    end
    id_rs1_addr = 5'd9;
    #1;
    tests++; if (load_use_stall !== 1'b1) begin fails++; $display("FAIL bp_hz_stall: got %0b want 1", load_use_stall); end
    step();
    tests++; if (ex_valid !== 1'b1 || bubble_cnt !== c0) begin fails++; $display("FAIL bp_hz_hold: got v=%0b cnt=%0d want 1 %0d", ex_valid, bubble_cnt, c0); end
    flush = 1;
    step();
    tests++; if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_mem_read !== 1'b0) begin fails++; $display("FAIL fl_kill: got v=%0b ctrl=%h mr=%0b want 0 0 0", ex_valid, ex_ctrl, ex_mem_read); end
    tests++; if (bubble_cnt !== c0 || ex_pc !== 32'h400) begin fails++; $display("FAIL fl_keep: got cnt=%0d pc=%h want %0d 400", bubble_cnt, ex_pc, c0); end
    idle();
    step();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 4)); id_rs2_addr = 5'($urandom_range(0, 4));
      id_rd_addr = 5'($urandom_range(0, 4));
      id_uses_rs1 = $urandom_range(0, 1); id_uses_rs2 = $urandom_range(0, 1);
      id_mem_read = ($urandom_range(0, 1) == 1); id_ctrl = CTRL_W'($urandom);
      ex_ready = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 9) == 0);
      #1;
      tests++;
      if (load_use_stall !== m_hazard() || id_ready !== m_id_ready()) begin
        fails++;
        $display("FAIL rand_comb cyc %0d: got stall=%0b ready=%0b want %0b %0b", cyc,
                 load_use_stall, id_ready, m_hazard(), m_id_ready());
      end
      step();
      tests++;
      if (ex_valid !== mv || ex_pc !== mpc || ex_rs1_data !== mrs1d || ex_rs2_data !== mrs2d ||
          ex_imm !== mimm || ex_rs1_addr !== mra1 || ex_rs2_addr !== mra2 || ex_rd_addr !== mrd ||
          ex_mem_read !== mmr || ex_ctrl !== mctrl || bubble_cnt !== mcnt) begin
        fails++;
        $display("FAIL rand_regs cyc %0d: got v=%0b pc=%h rd=%0d mr=%0b ctrl=%h cnt=%0d want v=%0b pc=%h rd=%0d mr=%0b ctrl=%h cnt=%0d",
                 cyc, ex_valid, ex_pc, ex_rd_addr, ex_mem_read, ex_ctrl, bubble_cnt,
                 mv, mpc, mrd, mmr, mctrl, mcnt);
      end
    end
    idle();
    step();
  endtask

  task automatic test_saturation();
    #2;
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_q;
    mcnt = 32'hFFFF_FFFE;
    // Chain of loads each reading the previous load's rd gives a bubble every other cycle
    issue(32'h500, 5'd5, 5'd5, 1, 5'd0, 0, 1);
    step();
    step();
    tests++; if (bubble_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_reach: got %h want ffffffff", bubble_cnt); end
    step();
    step();
    tests++; if (bubble_cnt !== 32'hFFFF_FFFF || mcnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_hold: got %h want ffffffff", bubble_cnt); end
  endtask

  task automatic test_async_reset();
    issue(32'h600, 5'd11, 5'd12, 1, 5'd13, 1, 1);
    step();
    issue(32'h604, 5'd14, 5'd15, 1, 5'd11, 1, 1);
    flush = 1; ex_ready = 1;
    #2;
    rst_n = 0;
    #1;
    m_reset();
    tests++; if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_rs1_data !== '0 || ex_rd_addr !== '0) begin fails++; $display("FAIL arst_regs: got v=%0b pc=%h rs1=%h rd=%0d want 0", ex_valid, ex_pc, ex_rs1_data, ex_rd_addr); end
    tests++; if (ex_ctrl !== '0 || ex_mem_read !== 1'b0 || bubble_cnt !== '0) begin fails++; $display("FAIL arst_ctl: got ctrl=%h mr=%0b cnt=%0d want 0", ex_ctrl, ex_mem_read, bubble_cnt); end
    idle();
    #1;
    rst_n = 1;
    step();
    tests++; if (ex_valid !== 1'b0 || bubble_cnt !== '0) begin fails++; $display("FAIL arst_after: got v=%0b cnt=%0d want 0 0", ex_valid, bubble_cnt); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_hazard();
    test_backpressure_flush();
    test_random();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
